exc_commit_ctrl: RTL and testbench
==================================

// Module: exc_commit_ctrl
// PURPOSE
//  Writeback-stage exception/ertn commit controller; drives the exception-report side of the CSR file.
//  - Inputs: per-instruction exception flags from WB, interrupt-pending state from the CSR file.
//  - Outputs: the one-cycle wb_ex/ertn_flush report the CSR file consumes.
//  - Owns pipeline redirect: holds flush target (eentry or era) until IF accepts it; blocks WB commits meanwhile.
// PARAMETERS
//  INT_W   13  width of estat.IS / ecfg.LIE interrupt vectors
//  PC_W    32  width of PC, vaddr, eentry, era
// PORTS
//  clk           in   1      clock, all state on rising edge
//  reset         in   1      synchronous, active-low (0 = reset)
//  ws_valid      in   1      WB holds a valid instruction this cycle
//  ws_allowin    out  1      WB may commit; 0 while a flush is outstanding
//  ws_pc         in   PC_W   PC of WB instruction
//  ws_vaddr      in   PC_W   data address of WB load/store
//  ws_adef       in   1      fetch address error
//  ws_ine        in   1      instruction not exist
//  ws_sys        in   1      syscall
//  ws_brk        in   1      break
//  ws_ale        in   1      address misaligned
//  ws_ertn       in   1      ertn instruction
//  csr_estat_is  in   INT_W  pending interrupt bits
//  csr_ecfg_lie  in   INT_W  local interrupt enables
//  csr_crmd_ie   in   1      global interrupt enable
//  csr_eentry    in   PC_W   exception entry address
//  csr_era       in   PC_W   exception return address
//  wb_ex         out  1      one-cycle exception commit pulse to CSR file
//  wb_ecode      out  6      exception code, valid with wb_ex
//  wb_esubcode   out  9      exception subcode, valid with wb_ex
//  wb_pc         out  PC_W   faulting PC, valid with wb_ex
//  wb_vaddr      out  PC_W   bad address (ALE: ws_vaddr; ADEF: ws_pc), valid with wb_ex
//  ertn_flush    out  1      one-cycle ertn commit pulse to CSR file
//  flush_valid   out  1      redirect request to IF
//  flush_target  out  PC_W   redirect PC, stable while flush_valid
//  flush_ready   in   1      IF accepts redirect
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE, int_pend=0.
//    Outputs: wb_ex=0, ertn_flush=0, flush_valid=0, ws_allowin=1; wb_ecode/esubcode/pc/vaddr/flush_target=0.
//  int_pend register <= |(csr_estat_is & csr_ecfg_lie) & csr_crmd_ie every cycle.
//    One-cycle latency from CSR change to interrupt eligibility.
//  commit = ws_valid & ws_allowin. Interrupt is attached to the committing instruction.
//  Priority, highest first, with ecode/esubcode:
//    INT 0x00/0 > ADEF 0x08/0 > INE 0x0D/0 > SYS 0x0B/0 > BRK 0x0C/0 > ALE 0x09/0.
//  ERTN: only if no exception/interrupt. Exception on an ertn instruction reports wb_ex only.
//  Outputs registered: wb_ex/ertn_flush high exactly one cycle after the commit edge; never both high.
//  wb_vaddr = ws_pc for ADEF, ws_vaddr for ALE, 0 otherwise.
//  FSM, two states:
//    IDLE:  ws_allowin=1. commit with exc/int -> FLUSH, flush_target<=csr_eentry.
//           commit with ertn -> FLUSH, flush_target<=csr_era. Otherwise stay.
//    FLUSH: ws_allowin=0, flush_valid=1, flush_target held.
//           flush_ready -> IDLE next cycle. ws_valid ignored (no wb_ex/ertn while in FLUSH).
//  flush_valid asserts the cycle after commit (together with wb_ex/ertn_flush pulse).
//    It is held until the flush_ready handshake; flush_ready while IDLE is ignored.
//  eentry/era sampled at commit edge; later CSR writes do not alter a held flush_target.
//  Reset mid-FLUSH: drop flush_valid, return to IDLE, no further pulse.
//  Interrupt pending with ws_valid=0: no action until next valid commit in IDLE.
// TESTING
//  1. ws_valid=1, ws_sys=1, pc=0x1c000100, eentry=0x1c008000 -> next cycle wb_ex=1, ecode=0x0B, wb_pc=0x1c000100, flush_target=0x1c008000.
//  2. ws_ale=1 & ws_ine=1, vaddr=0x00000003 -> ecode=0x0D, wb_vaddr=0; repeat ALE alone -> ecode=0x09, wb_vaddr=0x3.
//  3. estat_is[11]=1, lie[11]=1, crmd_ie=1 one cycle before commit of ws_brk=1 -> ecode=0x00 (INT wins); with crmd_ie=0 -> ecode=0x0C.
//  4. ws_ertn=1, era=0x1c000204 -> ertn_flush=1 one cycle, wb_ex=0, flush_target=0x1c000204.
//  5. Hold flush_ready=0 for 5 cycles with ws_valid=1 & ws_sys=1 -> flush_valid/target stable, ws_allowin=0, no second wb_ex; flush_ready=1 -> IDLE.
//  6. reset=0 during FLUSH -> next cycle flush_valid=0, ws_allowin=1, wb_ex=0.

Source files
------------

// File: rtl/exc_commit_ctrl.sv
// Writeback-stage exception/ertn commit controller: reports committed exceptions
// and ertn to the CSR file and holds the IF redirect until it is accepted.
module exc_commit_ctrl #(
    parameter int INT_W = 13,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ws_valid,
    output logic             ws_allowin,
    input  logic [PC_W-1:0]  ws_pc,
    input  logic [PC_W-1:0]  ws_vaddr,
    input  logic             ws_adef,
    input  logic             ws_ine,
    input  logic             ws_sys,
    input  logic             ws_brk,
    input  logic             ws_ale,
    input  logic             ws_ertn,
    input  logic [INT_W-1:0] csr_estat_is,
    input  logic [INT_W-1:0] csr_ecfg_lie,
    input  logic             csr_crmd_ie,
    input  logic [PC_W-1:0]  csr_eentry,
    input  logic [PC_W-1:0]  csr_era,
    output logic             wb_ex,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    output logic [PC_W-1:0]  wb_pc,
    output logic [PC_W-1:0]  wb_vaddr,
    output logic             ertn_flush,
    output logic             flush_valid,
    output logic [PC_W-1:0]  flush_target,
    input  logic             flush_ready
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    state_t state;
    logic   int_pend;
    logic   commit;

    logic            exc_hit;
    logic [5:0]      exc_code;
    logic [PC_W-1:0] exc_vaddr;

    assign commit = ws_valid & ws_allowin;

    // Priority decode; the interrupt rides on whichever instruction commits.
    always_comb begin
        exc_hit   = 1'b1;
        exc_code  = ECODE_INT;
        exc_vaddr = '0;
        if (int_pend) begin
            exc_code = ECODE_INT;
        end else if (ws_adef) begin
            exc_code  = ECODE_ADEF;
            exc_vaddr = ws_pc;
        end else if (ws_ine) begin
            exc_code = ECODE_INE;
        end else if (ws_sys) begin
            exc_code = ECODE_SYS;
        end else if (ws_brk) begin
            exc_code = ECODE_BRK;
        end else if (ws_ale) begin
            exc_code  = ECODE_ALE;
            exc_vaddr = ws_vaddr;
        end else begin
            exc_hit = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            int_pend     <= 1'b0;
            ws_allowin   <= 1'b1;
            wb_ex        <= 1'b0;
            ertn_flush   <= 1'b0;
            flush_valid  <= 1'b0;
            wb_ecode     <= '0;
            wb_esubcode  <= '0;
            wb_pc        <= '0;
            wb_vaddr     <= '0;
            flush_target <= '0;
        end else begin
            int_pend   <= (|(csr_estat_is & csr_ecfg_lie)) & csr_crmd_ie;
            wb_ex      <= 1'b0;
            ertn_flush <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit && exc_hit) begin
                        state        <= FLUSH;
                        ws_allowin   <= 1'b0;
                        flush_valid  <= 1'b1;
                        flush_target <= csr_eentry;
                        wb_ex        <= 1'b1;
                        wb_ecode     <= exc_code;
                        wb_esubcode  <= 9'd0;
                        wb_pc        <= ws_pc;
                        wb_vaddr     <= exc_vaddr;
                    end else if (commit && ws_ertn) begin
                        state        <= FLUSH;
                        ws_allowin   <= 1'b0;
                        flush_valid  <= 1'b1;
                        flush_target <= csr_era;
                        ertn_flush   <= 1'b1;
                    end
                end
                FLUSH: begin
                    // Target stays frozen until IF takes it; WB is stalled meanwhile.
                    if (flush_ready) begin
                        state       <= IDLE;
                        ws_allowin  <= 1'b1;
                        flush_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    ws_allowin  <= 1'b1;
                    flush_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed scenarios plus random traffic, all checked
// against a transaction-level model of commit/flush behaviour.
module tb_exc_commit_ctrl;

    localparam int INT_W = 13;
    localparam int PC_W  = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             ws_valid, ws_allowin;
    logic [PC_W-1:0]  ws_pc, ws_vaddr;
    logic             ws_adef, ws_ine, ws_sys, ws_brk, ws_ale, ws_ertn;
    logic [INT_W-1:0] csr_estat_is, csr_ecfg_lie;
    logic             csr_crmd_ie;
    logic [PC_W-1:0]  csr_eentry, csr_era;
    logic             wb_ex;
    logic [5:0]       wb_ecode;
    logic [8:0]       wb_esubcode;
    logic [PC_W-1:0]  wb_pc, wb_vaddr;
    logic             ertn_flush, flush_valid;
    logic [PC_W-1:0]  flush_target;
    logic             flush_ready;

    int errs = 0;
    int checks = 0;

    exc_commit_ctrl #(.INT_W(INT_W), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .ws_valid(ws_valid), .ws_allowin(ws_allowin),
        .ws_pc(ws_pc), .ws_vaddr(ws_vaddr),
        .ws_adef(ws_adef), .ws_ine(ws_ine), .ws_sys(ws_sys),
        .ws_brk(ws_brk), .ws_ale(ws_ale), .ws_ertn(ws_ertn),
        .csr_estat_is(csr_estat_is), .csr_ecfg_lie(csr_ecfg_lie),
        .csr_crmd_ie(csr_crmd_ie), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
        .flush_valid(flush_valid), .flush_target(flush_target),
        .flush_ready(flush_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a "redirect outstanding" flag plus the last report.
    bit              m_busy, m_int, m_ex, m_ertn;
    logic [5:0]      m_ecode;
    logic [PC_W-1:0] m_pc, m_vaddr, m_target;

    task automatic model_edge();
        bit         flg[6];
        logic [5:0] codes[6];
        int         win;
        bit         nxt_int;
        codes = '{6'h00, 6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        if (!reset) begin
            m_busy = 0; m_int = 0; m_ex = 0; m_ertn = 0;
            m_ecode = 0; m_pc = 0; m_vaddr = 0; m_target = 0;
            return;
        end
        nxt_int = ((csr_estat_is & csr_ecfg_lie) != 0) && csr_crmd_ie;
        m_ex = 0; m_ertn = 0;
        if (m_busy) begin
            if (flush_ready) m_busy = 0;
        end else if (ws_valid) begin
            flg = '{m_int, ws_adef, ws_ine, ws_sys, ws_brk, ws_ale};
            win = -1;
            for (int i = 5; i >= 0; i--) if (flg[i]) win = i;
            if (win >= 0) begin
                m_ex = 1; m_busy = 1; m_target = csr_eentry;
                m_ecode = codes[win]; m_pc = ws_pc;
                m_vaddr = (win == 1) ? ws_pc : (win == 5) ? ws_vaddr : '0;
            end else if (ws_ertn) begin
                m_ertn = 1; m_busy = 1; m_target = csr_era;
            end
        end
        m_int = nxt_int;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("wb_ex", 32'(wb_ex), 32'(m_ex));
        chk("ertn_flush", 32'(ertn_flush), 32'(m_ertn));
        chk("flush_valid", 32'(flush_valid), 32'(m_busy));
        chk("ws_allowin", 32'(ws_allowin), 32'(!m_busy));
        if (m_busy) chk("flush_target", flush_target, m_target);
        if (m_ex) begin
            chk("wb_ecode", 32'(wb_ecode), 32'(m_ecode));
            chk("wb_esubcode", 32'(wb_esubcode), 32'd0);
            chk("wb_pc", wb_pc, m_pc);
            chk("wb_vaddr", wb_vaddr, m_vaddr);
        end
    endtask

    task automatic quiet();
        ws_valid = 0; ws_adef = 0; ws_ine = 0; ws_sys = 0; ws_brk = 0;
        ws_ale = 0; ws_ertn = 0; flush_ready = 0;
        csr_estat_is = '0; csr_ecfg_lie = '0; csr_crmd_ie = 0;
    endtask

    task automatic drain();
        quiet();
        flush_ready = 1;
        step();
        flush_ready = 0;
    endtask

    logic [PC_W-1:0] held;

    initial begin
        quiet();
        ws_pc = 32'h1c000000; ws_vaddr = 0; csr_eentry = 0; csr_era = 0;
        reset = 0;
        step();
        chk("rst_ecode", 32'(wb_ecode), 32'd0);
        chk("rst_pc", wb_pc, 32'd0);
        chk("rst_vaddr", wb_vaddr, 32'd0);
        chk("rst_target", flush_target, 32'd0);
        reset = 1;
        step();

        // Syscall redirect to eentry
        ws_valid = 1; ws_sys = 1; ws_pc = 32'h1c000100; csr_eentry = 32'h1c008000;
        step();
        chk("t1_ecode", 32'(wb_ecode), 32'h0B);
        chk("t1_pc", wb_pc, 32'h1c000100);
        chk("t1_target", flush_target, 32'h1c008000);
        drain();

        // INE outranks ALE; ALE alone reports vaddr
        ws_valid = 1; ws_ale = 1; ws_ine = 1; ws_vaddr = 32'h3;
        step();
        chk("t2_ine", 32'(wb_ecode), 32'h0D);
        chk("t2_ine_va", wb_vaddr, 32'h0);
        drain();
        ws_valid = 1; ws_ale = 1; ws_vaddr = 32'h3;
        step();
        chk("t2_ale", 32'(wb_ecode), 32'h09);
        chk("t2_ale_va", wb_vaddr, 32'h3);
        drain();

        // Interrupt eligibility needs one cycle of latency
        csr_estat_is[11] = 1; csr_ecfg_lie[11] = 1; csr_crmd_ie = 1;
        step();
        ws_valid = 1; ws_brk = 1;
        step();
        chk("t3_int", 32'(wb_ecode), 32'h00);
        drain();
        csr_estat_is[11] = 1; csr_ecfg_lie[11] = 1; csr_crmd_ie = 0;
        step();
        ws_valid = 1; ws_brk = 1;
        step();
        chk("t3_brk", 32'(wb_ecode), 32'h0C);
        drain();

        // ertn redirect to era
        ws_valid = 1; ws_ertn = 1; csr_era = 32'h1c000204;
        step();
        chk("t4_ertn", 32'(ertn_flush), 32'd1);
        chk("t4_wbex", 32'(wb_ex), 32'd0);
        chk("t4_target", flush_target, 32'h1c000204);
        ws_valid = 0; ws_ertn = 0;
        step();
        chk("t4_pulse", 32'(ertn_flush), 32'd0);
        drain();

        // IF back-pressure: target held, WB stalled, no repeat report
        ws_valid = 1; ws_sys = 1;
        step();
        held = flush_target;
        for (int i = 0; i < 5; i++) begin
            csr_eentry = $urandom;
            step();
            chk("t5_hold", flush_target, held);
            chk("t5_stall", 32'(ws_allowin), 32'd0);
        end
        flush_ready = 1; ws_valid = 0; ws_sys = 0;
        step();
        chk("t5_idle", 32'(ws_allowin), 32'd1);
        flush_ready = 0;

        // Reset while a redirect is outstanding
        ws_valid = 1; ws_brk = 1;
        step();
        quiet();
        reset = 0;
        step();
        chk("t6_fv", 32'(flush_valid), 32'd0);
        chk("t6_allow", 32'(ws_allowin), 32'd1);
        chk("t6_wbex", 32'(wb_ex), 32'd0);
        reset = 1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 199) != 0);
            ws_valid     = ($urandom_range(0, 3) != 0);
            ws_pc        = $urandom;
            ws_vaddr     = $urandom;
            ws_adef      = ($urandom_range(0, 11) == 0);
            ws_ine       = ($urandom_range(0, 11) == 0);
            ws_sys       = ($urandom_range(0, 11) == 0);
            ws_brk       = ($urandom_range(0, 11) == 0);
            ws_ale       = ($urandom_range(0, 11) == 0);
            ws_ertn      = ($urandom_range(0, 5) == 0);
            csr_estat_is = ($urandom_range(0, 3) == 0) ? INT_W'(1) << $urandom_range(0, INT_W-1) : '0;
            csr_ecfg_lie = INT_W'($urandom);
            csr_crmd_ie  = ($urandom_range(0, 2) == 0);
            csr_eentry   = $urandom;
            csr_era      = $urandom;
            flush_ready  = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
